alu_op_sequencer: RTL and testbench

- Initiator side of the ALU operand/result interface. Accepts operation requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives the combinational ALU's i_arg0/i_arg1/i_oper from registers, captures o_result/o_flag one cycle later, and returns them on a valid/ready response port.
- Optional chaining replaces arg0 with the previous result, giving accumulator-style sequences.
- Sits between the communication unit's command decoder and the ALU instance.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_req_fifo.sv | 56 +++++
 rtl/alu_op_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// Request bundle, opcode values and sequencer FSM states.
package alu_pkg;

  localparam int WIDTH  = 6;
  localparam int OPER_W = 2;
  localparam int FLAG_W = 4;

  typedef logic [OPER_W-1:0] oper_t;
  typedef logic [FLAG_W-1:0] flag_t;

  localparam oper_t OP0 = 2'd0;
  localparam oper_t OP1 = 2'd1;
  localparam oper_t OP2 = 2'd2;
  localparam oper_t OP3 = 2'd3;

  typedef struct packed {
    logic signed [WIDTH-1:0] arg0;
    logic signed [WIDTH-1:0] arg1;
    oper_t                   oper;
    logic                    chain;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO for the ALU sequencer.
// Full/empty derive from registered occupancy only.
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  req_t i_data,
  input  logic i_pop,
  output req_t o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  req_t          mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;
  assign o_data  = mem_q[rd_q];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok)
        wr_q <= wr_q + 1'b1;
      if (pop_ok)
        rd_q <= rd_q + 1'b1;
      if (push_ok && !pop_ok)
        cnt_q <= cnt_q + 1'b1;
      else if (pop_ok && !push_ok)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (push_ok)
      mem_q[wr_q] <= i_data;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for the combinational ALU: queues requests, drives
// registered operands, captures result/flags, returns a response.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH  = alu_pkg::WIDTH,
  parameter int OPER_W = alu_pkg::OPER_W,
  parameter int FLAG_W = alu_pkg::FLAG_W,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [WIDTH-1:0]  i_req_arg0,
  input  logic [WIDTH-1:0]  i_req_arg1,
  input  logic [OPER_W-1:0] i_req_oper,
  input  logic              i_req_chain,
  output logic [WIDTH-1:0]  o_alu_arg0,
  output logic [WIDTH-1:0]  o_alu_arg1,
  output logic [OPER_W-1:0] o_alu_oper,
  input  logic [WIDTH-1:0]  i_alu_result,
  input  logic [FLAG_W-1:0] i_alu_flag,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [WIDTH-1:0]  o_rsp_result,
  output logic [FLAG_W-1:0] o_rsp_flag,
  output logic              o_busy
);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  arg0_q, arg1_q;
  logic [OPER_W-1:0] oper_q;
  logic [WIDTH-1:0]  res_q, acc_q;
  logic [FLAG_W-1:0] flag_q;
  logic              rvalid_q;

  logic              full, empty;
  logic              push, pop, cap;
  req_t              wr_req, head;
  logic [WIDTH-1:0]  arg0_d;

  assign wr_req.arg0  = i_req_arg0;
  assign wr_req.arg1  = i_req_arg1;
  assign wr_req.oper  = i_req_oper;
  assign wr_req.chain = i_req_chain;

  assign o_req_ready = !full;
  assign push        = i_req_valid && !full;

  alu_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (wr_req),
    .i_pop   (pop),
    .o_data  (head),
    .o_full  (full),
    .o_empty (empty)
  );

  assign arg0_d = head.chain ? acc_q : head.arg0;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cap     = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = ST_EXEC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      arg0_q   <= '0;
      arg1_q   <= '0;
      oper_q   <= '0;
      res_q    <= '0;
      acc_q    <= '0;
      flag_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        arg0_q <= arg0_d;
        arg1_q <= head.arg1;
        oper_q <= head.oper;
      end
      if (cap) begin
        res_q    <= i_alu_result;
        acc_q    <= i_alu_result;
        flag_q   <= i_alu_flag;
        rvalid_q <= 1'b1;
      end else if (state_q == ST_RESP && i_rsp_ready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign o_alu_arg0   = arg0_q;
  assign o_alu_arg1   = arg1_q;
  assign o_alu_oper   = oper_q;
  assign o_rsp_valid  = rvalid_q;
  assign o_rsp_result = res_q;
  assign o_rsp_flag   = flag_q;
  assign o_busy       = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a stub adder ALU
// and an in-order response scoreboard.
module tb_alu_op_sequencer;

  localparam int W = 6;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic signed [W-1:0] req_arg0, req_arg1;
  logic [1:0]        req_oper;
  logic              req_chain;
  logic [W-1:0]      alu_arg0, alu_arg1;
  logic [1:0]        alu_oper;
  logic [W-1:0]      alu_result;
  logic [3:0]        alu_flag;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_result;
  logic [3:0]        rsp_flag;
  logic              busy;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flag;
  } exp_t;

  exp_t          sb[$];
  logic [W-1:0]  acc_m;
  int            tests;
  int            fails;
  int            rsp_cnt;

  alu_op_sequencer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_arg0   (req_arg0),
    .i_req_arg1   (req_arg1),
    .i_req_oper   (req_oper),
    .i_req_chain  (req_chain),
    .o_alu_arg0   (alu_arg0),
    .o_alu_arg1   (alu_arg1),
    .o_alu_oper   (alu_oper),
    .i_alu_result (alu_result),
    .i_alu_flag   (alu_flag),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_flag   (rsp_flag),
    .o_busy       (busy)
  );

  // Stub ALU
  assign alu_result = alu_arg0 + alu_arg1;
  assign alu_flag   = {alu_oper, 2'b00};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: a response is consumed on the coming edge
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      exp_t e;
      tests++;
      rsp_cnt++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp: got result=%0d flag=%b, required none",
                 $signed(rsp_result), rsp_flag);
      end else begin
        e = sb.pop_front();
        if (rsp_result !== e.res || rsp_flag !== e.flag) begin
          fails++;
          $display("FAIL rsp: got result=%0d flag=%b, required result=%0d flag=%b",
                   $signed(rsp_result), rsp_flag, $signed(e.res), e.flag);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a0, input logic [W-1:0] a1,
                      input logic [1:0] op, input logic ch);
    int   n;
    exp_t e;
    n         = 0;
    req_valid = 1'b1;
    req_arg0  = a0;
    req_arg1  = a1;
    req_oper  = op;
    req_chain = ch;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got req_ready=0, required 1");
    end else begin
      e.res  = (ch ? acc_m : a0) + a1;
      e.flag = {op, 2'b00};
      acc_m  = e.res;
      sb.push_back(e);
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || rsp_valid || sb.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (busy || rsp_valid || sb.size() != 0) begin
      fails++;
      $display("FAIL idle_timeout: got busy=%b pending=%0d, required 0",
               busy, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_req_ready: got %b, required 1", req_ready);
    end
    tests++;
    if (alu_arg0 !== '0 || alu_arg1 !== '0 || alu_oper !== '0) begin
      fails++;
      $display("FAIL rst_alu: got %0d %0d %0d, required 0 0 0",
               alu_arg0, alu_arg1, alu_oper);
    end
    tests++;
    if (rsp_valid !== 1'b0 || rsp_result !== '0 || rsp_flag !== '0) begin
      fails++;
      $display("FAIL rst_rsp: got v=%b r=%0d f=%b, required 0 0 0",
               rsp_valid, rsp_result, rsp_flag);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_busy: got %b, required 0", busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_chain_from_reset();
    rsp_ready = 1'b1;
    send(6'd9, 6'd3, 2'd1, 1'b1);
    tick();
    tests++;
    if (alu_arg0 !== 6'd0) begin
      fails++;
      $display("FAIL chain_zero_acc: got arg0=%0d, required 0", alu_arg0);
    end
    wait_idle();
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    send(6'd2, 6'd13, 2'd0, 1'b0);
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL lat_k: got valid=%b, required 0", rsp_valid);
    end
    tick();
    tests++;
    if (rsp_valid !== 1'b0 || alu_arg0 !== 6'd2 || alu_arg1 !== 6'd13
        || alu_oper !== 2'd0) begin
      fails++;
      $display("FAIL lat_k1: got valid=%b a0=%0d a1=%0d op=%0d, required 0 2 13 0",
               rsp_valid, alu_arg0, alu_arg1, alu_oper);
    end
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 6'd15 || rsp_flag !== 4'b0000) begin
      fails++;
      $display("FAIL lat_k2: got valid=%b r=%0d f=%b, required 1 15 0000",
               rsp_valid, rsp_result, rsp_flag);
    end
    wait_idle();
  endtask

  task automatic test_wrap();
    rsp_ready = 1'b1;
    send(6'd17, 6'd18, 2'd2, 1'b0);
    wait_idle();
    tests++;
    if (rsp_result !== 6'b100011 || rsp_flag !== 4'b1000) begin
      fails++;
      $display("FAIL wrap: got r=%b f=%b, required 100011 1000",
               rsp_result, rsp_flag);
    end
  endtask

  task automatic test_chain();
    rsp_ready = 1'b1;
    send(6'd5, 6'd2, 2'd3, 1'b0);
    send(6'd9, 6'd1, 2'd1, 1'b1);
    wait_idle();
    tests++;
    if (alu_arg0 !== 6'd7 || rsp_result !== 6'd8 || rsp_flag !== 4'b0100) begin
      fails++;
      $display("FAIL chain: got a0=%0d r=%0d f=%b, required 7 8 0100",
               alu_arg0, rsp_result, rsp_flag);
    end
  endtask

  task automatic test_back_to_back();
    int start;
    start     = rsp_cnt;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(6'(i + 1), 6'd10, 2'(i), 1'b0);
    tests++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_ready: got %b, required 0", req_ready);
    end
    tick();
    tick();
    tests++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL full_hold: got ready=%b valid=%b busy=%b, required 0 1 1",
               req_ready, rsp_valid, busy);
    end
    rsp_ready = 1'b1;
    send(6'd31, 6'd31, 2'd3, 1'b0);
    wait_idle();
    tests++;
    if (rsp_cnt - start != 6) begin
      fails++;
      $display("FAIL b2b_count: got %0d, required 6", rsp_cnt - start);
    end
  endtask

  task automatic test_stall();
    int           n;
    logic [W-1:0] r0;
    logic [3:0]   f0;
    rsp_ready = 1'b0;
    send(6'd4, 6'd5, 2'd1, 1'b0);
    send(6'd1, 6'd1, 2'd0, 1'b0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    r0 = rsp_result;
    f0 = rsp_flag;
    tests++;
    if (rsp_valid !== 1'b1 || r0 !== 6'd9 || f0 !== 4'b0100) begin
      fails++;
      $display("FAIL stall_first: got v=%b r=%0d f=%b, required 1 9 0100",
               rsp_valid, r0, f0);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_result !== r0 || rsp_flag !== f0
          || alu_arg1 !== 6'd5) begin
        fails++;
        $display("FAIL stall_hold%0d: got v=%b r=%0d f=%b a1=%0d, required 1 %0d %b 5",
                 i, rsp_valid, rsp_result, rsp_flag, alu_arg1, r0, f0);
      end
    end
    rsp_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    send(6'd1, 6'd2, 2'd0, 1'b0);
    send(6'd3, 6'd4, 2'd1, 1'b0);
    send(6'd5, 6'd6, 2'd2, 1'b0);
    send(6'd7, 6'd8, 2'd3, 1'b0);
    rsp_ready = 1'b1;
    tick();
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_result !== '0 || rsp_flag !== '0
        || alu_arg0 !== '0 || alu_arg1 !== '0 || alu_oper !== '0
        || busy !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid: got v=%b r=%0d f=%b a0=%0d a1=%0d busy=%b rdy=%b, required all reset",
               rsp_valid, rsp_result, rsp_flag, alu_arg0, alu_arg1, busy, req_ready);
    end
    sb.delete();
    acc_m = '0;
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL rst_stale%0d: got valid=%b busy=%b, required 0 0",
                 i, rsp_valid, busy);
      end
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rsp_cnt   = 0;
    acc_m     = '0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_arg0  = '0;
    req_arg1  = '0;
    req_oper  = '0;
    req_chain = 1'b0;
    rsp_ready = 1'b0;
    #2;
    test_reset();
    test_chain_from_reset();
    test_single();
    test_wrap();
    test_chain();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
